// File: rtl/color_encoder_if.sv
// Pixel-in / packed-word-out handshake bundle for color_encoder.
// master = pixel producer plus word consumer; slave = the encoder.
interface color_encoder_if #(
  parameter int COLOR_W = 8
);
  logic               in_valid;
  logic [COLOR_W-1:0] in_pixel;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic [7:0]         out_word;
  logic               out_last;
  logic               out_ready;

  modport master (
    output in_valid, in_pixel, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_last
  );

  modport slave (
    input  in_valid, in_pixel, in_last, out_ready,
    output in_ready, out_valid, out_word, out_last
  );
endinterface

// File: rtl/color_encoder.sv
// Maps pixels to 2-bit palette codes and packs four per byte; word out 1 cycle after its closing pixel.
// in_ready = !out_valid || out_ready, so a held word stalls input while a draining word does not.
module color_encoder #(
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_palette,
  input  logic [COLOR_W-1:0] i_first_color,
  input  logic [COLOR_W-1:0] i_second_color,
  input  logic               i_err_clear,
  output logic [7:0]         o_err_count,
  color_encoder_if.slave     bus
);

  logic [COLOR_W-1:0] r_first;
  logic [COLOR_W-1:0] r_second;
  logic [1:0]         r_slot;
  logic [7:0]         r_acc;
  logic               r_out_valid;
  logic [7:0]         r_out_word;
  logic               r_out_last;
  logic [7:0]         r_err;

  logic               w_accept;
  logic               w_close;
  logic [1:0]         w_code;
  logic [7:0]         w_word;

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_word  = r_out_word;
  assign bus.out_last  = r_out_last;
  assign o_err_count   = r_err;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_close  = w_accept && ((r_slot == 2'd3) || bus.in_last);

  always_comb begin
    if (bus.in_pixel == r_first) begin
      w_code = 2'b00;
    end else if (bus.in_pixel == r_second) begin
      w_code = 2'b01;
    end else if (bus.in_pixel == '0) begin
      w_code = 2'b10;
    end else begin
      w_code = 2'b11;
    end
  end

  // Slots above the current one carry the pad code; harmless mid-word since later pixels overwrite them.
  always_comb begin
    w_word = r_acc;
    for (int k = 0; k < 4; k++) begin
      if (k == int'(r_slot)) begin
        w_word[2*k +: 2] = w_code;
      end else if (k > int'(r_slot)) begin
        w_word[2*k +: 2] = 2'b10;
      end
    end
  end

  // Palette is read combinationally above, so a same-cycle pixel sees the old entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first  <= '0;
      r_second <= '0;
    end else if (i_load_palette) begin
      r_first  <= i_first_color;
      r_second <= i_second_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= 2'd0;
      r_acc  <= 8'd0;
    end else if (w_accept) begin
      if (w_close) begin
        r_slot <= 2'd0;
        r_acc  <= 8'd0;
      end else begin
        r_slot <= r_slot + 2'd1;
        r_acc  <= w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_word  <= 8'd0;
      r_out_last  <= 1'b0;
    end else if (w_close) begin
      r_out_valid <= 1'b1;
      r_out_word  <= w_word;
      r_out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 8'd0;
    end else if (i_err_clear) begin
      r_err <= 8'd0;
    end else if (w_accept && (w_code == 2'b11) && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'd1;
    end
  end

endmodule

// File: tb/tb_color_encoder.sv
// Scoreboard bench for color_encoder: a bench-side encoder model queues expected words as pixels are accepted.
module tb_color_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] f_col = 8'd0;
  logic [7:0] s_col = 8'd0;
  logic       clr = 1'b0;
  logic [7:0] err_cnt;

  color_encoder_if #(.COLOR_W(8)) bus();

  color_encoder #(.COLOR_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load_palette (ld),
    .i_first_color  (f_col),
    .i_second_color (s_col),
    .i_err_clear    (clr),
    .o_err_count    (err_cnt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         stalls = 0;
  logic [8:0] sb[$];
  int         pop_cyc[$];
  logic [7:0] m_first = 8'd0;
  logic [7:0] m_second = 8'd0;
  logic [7:0] m_acc = 8'd0;
  int         m_slot = 0;
  int         m_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] enc(input logic [7:0] p);
    if (p == m_first)  return 2'b00;
    if (p == m_second) return 2'b01;
    if (p == 8'd0)     return 2'b10;
    return 2'b11;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_word", 32'(bus.out_valid), 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("word", 32'(bus.out_word), 32'(e[7:0]));
        chk("last", 32'(bus.out_last), 32'(e[8]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pixel is taken.
  task automatic send_px(input logic [7:0] pix, input bit last, input bit ldp = 1'b0,
                         input logic [7:0] f = 8'd0, input logic [7:0] s = 8'd0,
                         input bit clrp = 1'b0);
    logic [1:0] code;
    int         waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
    bus.in_last  = last;
    ld = ldp; f_col = f; s_col = s; clr = clrp;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
      waited++;
      if (waited > 200) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        ld = 1'b0; clr = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    code = enc(pix);
    m_acc[2*m_slot +: 2] = code;
    if (m_slot == 3 || last) begin
      for (int k = m_slot + 1; k < 4; k++) m_acc[2*k +: 2] = 2'b10;
      sb.push_back({last, m_acc});
      m_acc = 8'd0;
      m_slot = 0;
    end else begin
      m_slot++;
    end
    if (clrp) m_err = 0;
    else if (code == 2'b11 && m_err < 255) m_err++;
    if (ldp) begin
      m_first = f;
      m_second = s;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    ld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic load_pal(input logic [7:0] f, input logic [7:0] s);
    ld = 1'b1; f_col = f; s_col = s;
    @(posedge clk);
    #1;
    ld = 1'b0;
    m_first = f;
    m_second = s;
  endtask

  task automatic clear_err();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    m_err = 0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat[8];
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 8'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_word",  32'(bus.out_word),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_err",       32'(err_cnt),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero palette after reset: pixel 0 hits first entry
    send_px(8'd0, 1'b0); send_px(8'd0, 1'b0); send_px(8'd0, 1'b0); send_px(8'd5, 1'b0);
    drain("zero_pal");

    clear_err();
    load_pal(8'd120, 8'd210);
    send_px(8'd120, 1'b0); send_px(8'd210, 1'b0); send_px(8'd0, 1'b0); send_px(8'd55, 1'b0);
    drain("basic");
    chk("basic_err_is_1", 32'(err_cnt), 32'd1);

    send_px(8'd210, 1'b0); send_px(8'd120, 1'b1);
    drain("short_last");

    // Palette load concurrent with a pixel: that pixel uses the old palette
    send_px(8'd120, 1'b0, 1'b1, 8'd7, 8'd9);
    send_px(8'd7, 1'b0); send_px(8'd9, 1'b0); send_px(8'd210, 1'b0);
    drain("pal_swap");

    pat[0] = 8'd7; pat[1] = 8'd9; pat[2] = 8'd0; pat[3] = 8'd1;
    pat[4] = 8'd9; pat[5] = 8'd7; pat[6] = 8'd1; pat[7] = 8'd0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_px(pat[i], 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_pending",   32'(sb.size()),     32'd1);
        if (sb.size() > 0) chk("bp_held_word", 32'(bus.out_word), 32'(sb[0][7:0]));
        repeat (3) @(negedge clk);
        if (sb.size() > 0) chk("bp_held_word2", 32'(bus.out_word), 32'(sb[0][7:0]));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("backpressure");

    stalls = 0;
    pop_cyc.delete();
    for (int i = 0; i < 12; i++) send_px(8'(i % 3), 1'b0);
    drain("stream");
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_words", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("stream_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);
      chk("stream_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd4);
    end

    for (int i = 0; i < 260; i++) send_px(8'd77, 1'b0);
    drain("err_sat");
    chk("err_is_255", 32'(err_cnt), 32'd255);
    send_px(8'd77, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    chk("err_clear_wins", 32'(err_cnt), 32'(m_err));
    send_px(8'd77, 1'b1);
    drain("err_tail");

    // Reset with two pixels of a word in flight
    send_px(8'd5, 1'b0); send_px(8'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_word",  32'(bus.out_word),  32'd0);
    chk("mid_rst_out_last",  32'(bus.out_last),  32'd0);
    chk("mid_rst_err",       32'(err_cnt),       32'd0);
    sb.delete();
    m_acc = 8'd0; m_slot = 0; m_err = 0; m_first = 8'd0; m_second = 8'd0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_px(8'd0, 1'b0); send_px(8'd1, 1'b0); send_px(8'd2, 1'b0); send_px(8'd0, 1'b0);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
